riscv_core_dpath_resp_queue: RTL and testbench

//   Parametrised data-memory response queue for the bypassing 5-stage core.

---
 rtl/riscv_core_dpath_resp_queue_pkg.sv | 17 +
 rtl/riscv_core_dpath_resp_queue_load_align.sv | 43 ++++
 rtl/riscv_core_dpath_resp_queue.sv | 118 +++++++++++
 tb/tb_riscv_core_dpath_resp_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_dpath_resp_queue_pkg.sv
// Shared load-type codes for the data-memory response path.
// Both control and datapath import this package so the encoding of
// lw/lb/lbu/lh/lhu lives in exactly one place. Codes 5..7 are reserved.

package riscv_core_dpath_resp_queue_pkg;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ldType_e;

    localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/riscv_core_dpath_resp_queue_load_align.sv
// Combinational load alignment: picks the byte or halfword lane named by the
// address offset and sign- or zero-extends it to a full word.
// Misaligned halfwords use offset[1] only and misaligned words are passed
// through whole; no fault is raised here. Reserved type codes produce zero.

module riscv_core_dpath_load_align
    import riscv_core_dpath_resp_queue_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [2:0]        type_i,
    input  logic [1:0]        offset_i,
    output logic [DATA_W-1:0] result_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Select the addressed byte and halfword lanes out of the raw word
    always_comb begin
        byteLane = data_i[7:0];
        case (offset_i)
            2'd0:    byteLane = data_i[7:0];
            2'd1:    byteLane = data_i[15:8];
            2'd2:    byteLane = data_i[23:16];
            default: byteLane = data_i[31:24];
        endcase
        halfLane = offset_i[1] ? data_i[31:16] : data_i[15:0];
    end

    // Extend the chosen lane according to the load type
    always_comb begin
        result_o = '0;
        case (type_i)
            LD_W:    result_o = data_i;
            LD_B:    result_o = {{24{byteLane[7]}}, byteLane};
            LD_BU:   result_o = {24'h0, byteLane};
            LD_H:    result_o = {{16{halfLane[15]}}, halfLane};
            LD_HU:   result_o = {16'h0, halfLane};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_core_dpath_resp_queue.sv
// Data-memory response queue sitting between the dmem response port and the
// M-stage writeback mux. Buffers up to DEPTH formatted load responses so M/W
// can stall without losing data; flush drops everything on a squash.
// Words are aligned/extended on the way in, so the head is ready to use.
// Optional feature: define RISCV_RESPQ_BYPASS_EN to let a response flow
// straight through to deq_* in the same cycle when the queue is empty.

module riscv_core_dpath_resp_queue
    import riscv_core_dpath_resp_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              enq_val,
    output logic              enq_rdy,
    input  logic [DATA_W-1:0] enq_data,
    input  logic [2:0]        enq_type,
    input  logic [1:0]        enq_offset,
    output logic              deq_val,
    input  logic              deq_rdy,
    output logic [DATA_W-1:0] deq_data,
    output logic [CNT_W-1:0]  count
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] storage [DEPTH];

    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [CNT_W-1:0] count_q,   count_d;

    logic [DATA_W-1:0] alignedData;
    logic              bypassActive;
    logic              enqFire;
    logic              deqFire;
    logic              doWrite;
    logic              doRead;

    riscv_core_dpath_load_align u_align (
        .data_i   (enq_data),
        .type_i   (enq_type),
        .offset_i (enq_offset),
        .result_o (alignedData)
    );

`ifdef RISCV_RESPQ_BYPASS_EN
    assign bypassActive = (count_q == '0) && enq_val && !flush;
`else
    assign bypassActive = 1'b0;
`endif

    // Handshakes: a full queue never accepts, even while it is dequeuing,
    // and flush blocks both sides so nothing slips through a squash.
    // A bypassed response taken by M that cycle never touches storage.
    always_comb begin
        enq_rdy  = (count_q != FULL_CNT) && !flush;
        deq_val  = !flush && ((count_q != '0) || bypassActive);
        deq_data = bypassActive ? alignedData : storage[headPtr_q];
        enqFire  = enq_val && enq_rdy;
        deqFire  = deq_val && deq_rdy;
        doWrite  = enqFire && !(bypassActive && deq_rdy);
        doRead   = deqFire && !bypassActive;
    end

    // Next-state for pointers and occupancy; pointers wrap at DEPTH-1 so
    // non-power-of-two depths work, and flush clears everything.
    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (flush) begin
            headPtr_d = '0;
            tailPtr_d = '0;
            count_d   = '0;
        end else begin
            if (doWrite) begin
                tailPtr_d = (tailPtr_q == LAST_IDX) ? '0 : tailPtr_q + PTR_W'(1);
            end
            if (doRead) begin
                headPtr_d = (headPtr_q == LAST_IDX) ? '0 : headPtr_q + PTR_W'(1);
            end
            case ({doWrite, doRead})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers; reset drops all entries the same way flush does
    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
        end
    end

    // Storage array is left unreset; only valid slots are ever read out
    always_ff @(posedge clk) begin
        if (doWrite && !flush) begin
            storage[tailPtr_q] <= alignedData;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_riscv_core_dpath_resp_queue.sv
// Directed self-checking bench for riscv_core_dpath_resp_queue (DEPTH=4).
// Expected values are hand-computed constants or come from a small
// scoreboard queue. Expectations adapt to RISCV_RESPQ_BYPASS_EN.

module tb_riscv_core_dpath_resp_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        enqVal;
    logic        enqRdy;
    logic [31:0] enqData;
    logic [2:0]  enqType;
    logic [1:0]  enqOffset;
    logic        deqVal;
    logic        deqRdy;
    logic [31:0] deqData;
    logic [2:0]  dutCount;

    int testsRun  = 0;
    int failCount = 0;

    logic [31:0] model [$];

    riscv_core_dpath_resp_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .enq_val    (enqVal),
        .enq_rdy    (enqRdy),
        .enq_data   (enqData),
        .enq_type   (enqType),
        .enq_offset (enqOffset),
        .deq_val    (deqVal),
        .deq_rdy    (deqRdy),
        .deq_data   (deqData),
        .count      (dutCount)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic val, input logic [31:0] data,
                                 input logic [2:0] ty, input logic [1:0] off,
                                 input logic dRdy, input logic fl);
        enqVal    = val;
        enqData   = data;
        enqType   = ty;
        enqOffset = off;
        deqRdy    = dRdy;
        flush     = fl;
        #1;
    endtask

    task automatic enqOne(input logic [31:0] data, input logic [2:0] ty,
                          input logic [1:0] off);
        applyStimulus(1'b1, data, ty, off, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic drainCheck(input string tag, input logic [31:0] expected);
        applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b1, 1'b0);
        checkOutput({tag, "_val"}, 32'(deqVal), 32'd1);
        checkOutput({tag, "_data"}, deqData, expected);
        tick();
        applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) begin
            checkOutput("idle_count", 32'(dutCount), 32'd0);
            checkOutput("idle_deqval", 32'(deqVal), 32'd0);
            checkOutput("idle_enqrdy", 32'(enqRdy), 32'd1);
            tick();
        end

        // Fill with lw 0x11..0x44 while M is stalled
        enqOne(32'h11, 3'd0, 2'd0);
        enqOne(32'h22, 3'd0, 2'd0);
        enqOne(32'h33, 3'd0, 2'd0);
        enqOne(32'h44, 3'd0, 2'd0);
        checkOutput("full_count", 32'(dutCount), 32'd4);
        checkOutput("full_enqrdy", 32'(enqRdy), 32'd0);

        // Full queue with enq and deq together: only the dequeue happens
        applyStimulus(1'b1, 32'h55, 3'd0, 2'd0, 1'b1, 1'b0);
        checkOutput("full_deq_head", deqData, 32'h11);
        checkOutput("full_deq_enqrdy", 32'(enqRdy), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
        checkOutput("full_deq_count", 32'(dutCount), 32'd3);
        drainCheck("fill_22", 32'h22);
        drainCheck("fill_33", 32'h33);
        drainCheck("fill_44", 32'h44);
        checkOutput("fill_empty_count", 32'(dutCount), 32'd0);
        checkOutput("fill_empty_val", 32'(deqVal), 32'd0);

        // lb across all four byte lanes
        enqOne(32'h80FF7F01, 3'd1, 2'd0);
        enqOne(32'h80FF7F01, 3'd1, 2'd1);
        enqOne(32'h80FF7F01, 3'd1, 2'd2);
        enqOne(32'h80FF7F01, 3'd1, 2'd3);
        drainCheck("lb_off0", 32'h00000001);
        drainCheck("lb_off1", 32'h0000007F);
        drainCheck("lb_off2", 32'hFFFFFFFF);
        drainCheck("lb_off3", 32'hFFFFFF80);

        // Halfwords, unsigned byte, reserved type
        enqOne(32'h80FF7F01, 3'd4, 2'd2);
        enqOne(32'h80FF7F01, 3'd3, 2'd2);
        enqOne(32'h80FF7F01, 3'd2, 2'd3);
        enqOne(32'h80FF7F01, 3'd5, 2'd0);
        drainCheck("lhu_off2", 32'h000080FF);
        drainCheck("lh_off2", 32'hFFFF80FF);
        drainCheck("lbu_off3", 32'h00000080);
        drainCheck("reserved", 32'h00000000);

        // Misaligned lh and lw use the truncated lane / whole word
        enqOne(32'h80FF7F01, 3'd3, 2'd1);
        enqOne(32'h80FF7F01, 3'd0, 2'd3);
        drainCheck("lh_misalign", 32'h00007F01);
        drainCheck("lw_misalign", 32'h80FF7F01);

        // count=2, simultaneous enq/deq over 10 cycles wraps the pointers
        enqOne(32'hA1, 3'd0, 2'd0);
        enqOne(32'hA2, 3'd0, 2'd0);
        model.push_back(32'hA1);
        model.push_back(32'hA2);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 32'hB0 + 32'(k), 3'd0, 2'd0, 1'b1, 1'b0);
            checkOutput("wrap_head", deqData, model[0]);
            tick();
            void'(model.pop_front());
            model.push_back(32'hB0 + 32'(k));
            checkOutput("wrap_count", 32'(dutCount), 32'd2);
        end
        applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
        drainCheck("wrap_tail0", model[0]);
        drainCheck("wrap_tail1", model[1]);
        model.delete();

        // Flush with count=3 and an enqueue attempt in the same cycle
        enqOne(32'hC1, 3'd0, 2'd0);
        enqOne(32'hC2, 3'd0, 2'd0);
        enqOne(32'hC3, 3'd0, 2'd0);
        applyStimulus(1'b1, 32'hEE, 3'd0, 2'd0, 1'b1, 1'b1);
        checkOutput("flush_deqval", 32'(deqVal), 32'd0);
        checkOutput("flush_enqrdy", 32'(enqRdy), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
        checkOutput("post_flush_count", 32'(dutCount), 32'd0);
        checkOutput("post_flush_deqval", 32'(deqVal), 32'd0);
        enqOne(32'hD1, 3'd0, 2'd0);
        drainCheck("post_flush_first", 32'hD1);
        checkOutput("post_flush_empty", 32'(dutCount), 32'd0);

        // Reset mid-operation drops entries
        enqOne(32'hE1, 3'd0, 2'd0);
        enqOne(32'hE2, 3'd0, 2'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_count", 32'(dutCount), 32'd0);
        checkOutput("midreset_deqval", 32'(deqVal), 32'd0);

        // Empty-queue latency, with and without the bypass path
        applyStimulus(1'b1, 32'hDEADBEEF, 3'd0, 2'd0, 1'b1, 1'b0);
`ifdef RISCV_RESPQ_BYPASS_EN
        checkOutput("byp_same_val", 32'(deqVal), 32'd1);
        checkOutput("byp_same_data", deqData, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
        checkOutput("byp_count", 32'(dutCount), 32'd0);
        checkOutput("byp_after_val", 32'(deqVal), 32'd0);
`else
        checkOutput("nobyp_same_val", 32'(deqVal), 32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 3'd0, 2'd0, 1'b0, 1'b0);
        checkOutput("nobyp_count", 32'(dutCount), 32'd1);
        drainCheck("nobyp_next", 32'hDEADBEEF);
        checkOutput("nobyp_empty", 32'(dutCount), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
